// File: rtl/rvc_ctrl_pkg.sv
// Shared control encodings for the RV32C decoder and its immediate generator.
package rvc_ctrl_pkg;

  // ALU category field, CtrlALUOp[3:2]
  localparam logic [1:0] ALUBT = 2'b00;
  localparam logic [1:0] ALUAS = 2'b01;
  localparam logic [1:0] ALUSH = 2'b10;
  localparam logic [1:0] ALUFL = 2'b11;

  // Bitwise ops
  localparam logic [1:0] BTXOR = 2'b01;
  localparam logic [1:0] BTOR  = 2'b10;
  localparam logic [1:0] BTAND = 2'b11;

  // Add/sub and flag ops
  localparam logic [1:0] AFSUBS = 2'b00;
  localparam logic [1:0] AFADD  = 2'b01;
  localparam logic [1:0] AFSUBU = 2'b10;
  localparam logic [1:0] AFEQU  = 2'b11;

  // Shift ops
  localparam logic [1:0] SHSLL = 2'b00;
  localparam logic [1:0] SHSRL = 2'b10;
  localparam logic [1:0] SHSRA = 2'b11;

  // Program counter modes
  localparam logic [1:0] PCINC  = 2'b00;
  localparam logic [1:0] PCBRCH = 2'b01;
  localparam logic [1:0] PCJREG = 2'b10;
  localparam logic [1:0] PCJIMM = 2'b11;

  // LSU access widths, CtrlLSU[1:0]
  localparam logic [1:0] LSN = 2'b00;
  localparam logic [1:0] LSW = 2'b01;
  localparam logic [1:0] LSH = 2'b10;
  localparam logic [1:0] LSB = 2'b11;

  // Immediate layouts; LWSP differs from plain CI so it gets its own entry
  typedef enum logic [3:0] {
    IMM_NONE,
    IMM_CI,
    IMM_LWSP,
    IMM_CSS,
    IMM_CIW,
    IMM_CL,
    IMM_CS,
    IMM_CB,
    IMM_CJ,
    IMM_LUI,
    IMM_16SP
  } immFmt_t;

  // Load/store sequencing phase
  typedef enum logic {
    PH_ADDR = 1'b0,
    PH_DATA = 1'b1
  } phase_t;

  // RV32E only has x0..x15, so the top index bit is dropped
  function automatic logic [4:0] regIdx(input logic [4:0] r, input bit emb);
    return emb ? {1'b0, r[3:0]} : r;
  endfunction

endpackage

// File: rtl/rvc_imm_gen.sv
// Immediate extraction for every RVC instruction layout.
module rvc_imm_gen
  import rvc_ctrl_pkg::*;
(
  input  immFmt_t      Format,
  input  logic [12:2]  InstrBits,
  output logic [31:0]  Immediate
);

  // Unscramble the immediate bits of the selected layout
  always_comb begin
    Immediate = '0;
    unique case (Format)
      IMM_CI:   Immediate = {{26{InstrBits[12]}}, InstrBits[12], InstrBits[6:2]};
      IMM_LWSP: Immediate = {24'b0, InstrBits[3:2], InstrBits[12], InstrBits[6:4], 2'b0};
      IMM_CSS:  Immediate = {24'b0, InstrBits[8:7], InstrBits[12:9], 2'b0};
      IMM_CIW:  Immediate = {22'b0, InstrBits[10:7], InstrBits[12:11], InstrBits[5],
                             InstrBits[6], 2'b0};
      IMM_CL,
      IMM_CS:   Immediate = {25'b0, InstrBits[5], InstrBits[12:10], InstrBits[6], 2'b0};
      IMM_CB:   Immediate = {{23{InstrBits[12]}}, InstrBits[12], InstrBits[6:5], InstrBits[2],
                             InstrBits[11:10], InstrBits[4:3], 1'b0};
      IMM_CJ:   Immediate = {{20{InstrBits[12]}}, InstrBits[12], InstrBits[8], InstrBits[10:9],
                             InstrBits[6], InstrBits[7], InstrBits[2], InstrBits[11],
                             InstrBits[5:3], 1'b0};
      IMM_LUI:  Immediate = {{14{InstrBits[12]}}, InstrBits[12], InstrBits[6:2], 12'b0};
      IMM_16SP: Immediate = {{22{InstrBits[12]}}, InstrBits[12], InstrBits[4:3], InstrBits[5],
                             InstrBits[2], InstrBits[6], 4'b0};
      default:  Immediate = '0;
    endcase
  end

endmodule

// File: rtl/rvc_decoder.sv
// RV32C/RV32EC compressed instruction decoder with load/store phase sequencing.
module rvc_decoder
  import rvc_ctrl_pkg::*;
#(
  parameter bit embedded = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] InstructionIn,
  output logic [4:0]  Rs1,
  output logic [4:0]  Rs2,
  output logic [4:0]  Rd,
  output logic [31:0] Immediate,
  output logic [3:0]  CtrlLSU,
  output logic        CtrlMultiCycle,
  output logic        CtrlALUImm,
  output logic [3:0]  CtrlALUOp,
  output logic        CtrlFlagInv,
  output logic        CtrlPCWriteback,
  output logic [1:0]  CtrlPCMode
);

  phase_t      phase;
  phase_t      phaseNext;
  immFmt_t     immFmt;
  logic [4:0]  rs1Dec, rs2Dec, rdDec;
  logic [3:0]  lsuDec, aluOpDec;
  logic        aluImmDec, flagInvDec, pcWbDec;
  logic [1:0]  pcModeDec;
  logic        memOp, addrPhase;

  logic [2:0]  funct3;
  logic [4:0]  rdFull, rs2Full, rdPrime, rs1Prime;

  assign funct3   = InstructionIn[15:13];
  assign rdFull   = InstructionIn[11:7];
  assign rs2Full  = InstructionIn[6:2];
  assign rdPrime  = {2'b01, InstructionIn[4:2]};
  assign rs1Prime = {2'b01, InstructionIn[9:7]};

  rvc_imm_gen immGen (
    .Format    (immFmt),
    .InstrBits (InstructionIn[12:2]),
    .Immediate (Immediate)
  );

  // Instruction field decode; anything unrecognised stays at the all-zero NOP
  always_comb begin
    rs1Dec     = '0;
    rs2Dec     = '0;
    rdDec      = '0;
    immFmt     = IMM_NONE;
    lsuDec     = '0;
    aluImmDec  = 1'b0;
    aluOpDec   = '0;
    flagInvDec = 1'b0;
    pcWbDec    = 1'b0;
    pcModeDec  = PCINC;
    case (InstructionIn[1:0])
      2'b00: begin
        case (funct3)
          3'b000: if (InstructionIn[12:5] != '0) begin  // C.ADDI4SPN
            rdDec = rdPrime; rs1Dec = 5'd2; immFmt = IMM_CIW;
            aluOpDec = {ALUAS, AFADD}; aluImmDec = 1'b1;
          end
          3'b010: begin  // C.LW
            rdDec = rdPrime; rs1Dec = rs1Prime; immFmt = IMM_CL;
            aluOpDec = {ALUAS, AFADD}; aluImmDec = 1'b1; lsuDec = {2'b00, LSW};
          end
          3'b110: begin  // C.SW
            rs1Dec = rs1Prime; rs2Dec = rdPrime; immFmt = IMM_CS;
            aluOpDec = {ALUAS, AFADD}; aluImmDec = 1'b1; lsuDec = {2'b01, LSW};
          end
          default: ;
        endcase
      end
      2'b01: begin
        case (funct3)
          3'b000: begin  // C.ADDI / C.NOP
            rdDec = rdFull; rs1Dec = rdFull; immFmt = IMM_CI;
            aluOpDec = {ALUAS, AFADD}; aluImmDec = 1'b1;
          end
          3'b001: begin  // C.JAL
            rdDec = 5'd1; pcWbDec = 1'b1; pcModeDec = PCJIMM; immFmt = IMM_CJ;
          end
          3'b010: begin  // C.LI
            rdDec = rdFull; immFmt = IMM_CI;
            aluOpDec = {ALUAS, AFADD}; aluImmDec = 1'b1;
          end
          3'b011: if ({InstructionIn[12], rs2Full} != '0) begin
            aluOpDec = {ALUAS, AFADD}; aluImmDec = 1'b1; rdDec = rdFull;
            if (rdFull == 5'd2) begin  // C.ADDI16SP
              rs1Dec = 5'd2; immFmt = IMM_16SP;
            end else begin  // C.LUI
              immFmt = IMM_LUI;
            end
          end
          3'b100: begin
            case (InstructionIn[11:10])
              2'b00: if (!InstructionIn[12]) begin  // C.SRLI
                rdDec = rs1Prime; rs1Dec = rs1Prime; immFmt = IMM_CI;
                aluOpDec = {ALUSH, SHSRL}; aluImmDec = 1'b1;
              end
              2'b01: if (!InstructionIn[12]) begin  // C.SRAI
                rdDec = rs1Prime; rs1Dec = rs1Prime; immFmt = IMM_CI;
                aluOpDec = {ALUSH, SHSRA}; aluImmDec = 1'b1;
              end
              2'b10: begin  // C.ANDI
                rdDec = rs1Prime; rs1Dec = rs1Prime; immFmt = IMM_CI;
                aluOpDec = {ALUBT, BTAND}; aluImmDec = 1'b1;
              end
              default: if (!InstructionIn[12]) begin  // register-register ALU ops
                rdDec = rs1Prime; rs1Dec = rs1Prime; rs2Dec = rdPrime;
                case (InstructionIn[6:5])
                  2'b00:   aluOpDec = {ALUAS, AFSUBS};
                  2'b01:   aluOpDec = {ALUBT, BTXOR};
                  2'b10:   aluOpDec = {ALUBT, BTOR};
                  default: aluOpDec = {ALUBT, BTAND};
                endcase
              end
            endcase
          end
          3'b101: begin  // C.J
            pcModeDec = PCJIMM; immFmt = IMM_CJ;
          end
          default: begin  // C.BEQZ / C.BNEZ
            rs1Dec = rs1Prime; immFmt = IMM_CB; aluOpDec = {ALUFL, AFEQU};
            pcModeDec = PCBRCH; flagInvDec = funct3[0];
          end
        endcase
      end
      2'b10: begin
        case (funct3)
          3'b000: if (!InstructionIn[12]) begin  // C.SLLI
            rdDec = rdFull; rs1Dec = rdFull; immFmt = IMM_CI;
            aluOpDec = {ALUSH, SHSLL}; aluImmDec = 1'b1;
          end
          3'b010: if (rdFull != '0) begin  // C.LWSP
            rdDec = rdFull; rs1Dec = 5'd2; immFmt = IMM_LWSP;
            aluOpDec = {ALUAS, AFADD}; aluImmDec = 1'b1; lsuDec = {2'b00, LSW};
          end
          3'b110: begin  // C.SWSP
            rs1Dec = 5'd2; rs2Dec = rs2Full; immFmt = IMM_CSS;
            aluOpDec = {ALUAS, AFADD}; aluImmDec = 1'b1; lsuDec = {2'b01, LSW};
          end
          3'b100: begin
            if (rs2Full == '0) begin
              if (rdFull != '0) begin  // C.JR / C.JALR; rd=0 forms are reserved or C.EBREAK
                rs1Dec = rdFull; pcModeDec = PCJREG;
                if (InstructionIn[12]) begin
                  rdDec = 5'd1; pcWbDec = 1'b1;
                end
              end
            end else begin  // C.MV / C.ADD
              rdDec = rdFull; rs2Dec = rs2Full; aluOpDec = {ALUAS, AFADD};
              if (InstructionIn[12]) rs1Dec = rdFull;
            end
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  assign memOp = (lsuDec[1:0] != LSN);

  // Phase sequencing: a memory op spends one address cycle before completing
  always_comb begin
    phaseNext = PH_ADDR;
    if (phase == PH_ADDR && memOp) phaseNext = PH_DATA;
  end

  // Phase register
  always_ff @(posedge clk) begin
    if (rst) phase <= PH_ADDR;
    else     phase <= phaseNext;
  end

  // Output shaping: suppress writeback and hold PC during the address cycle
  always_comb begin
    addrPhase       = memOp && (phase == PH_ADDR);
    CtrlMultiCycle  = addrPhase;
    Rs1             = regIdx(rs1Dec, embedded);
    Rs2             = regIdx(rs2Dec, embedded);
    Rd              = regIdx(addrPhase ? 5'd0 : rdDec, embedded);
    CtrlLSU         = lsuDec;
    CtrlALUImm      = aluImmDec;
    CtrlALUOp       = aluOpDec;
    CtrlFlagInv     = flagInvDec;
    CtrlPCWriteback = pcWbDec;
    CtrlPCMode      = pcModeDec;
  end

endmodule

// File: tb/tb_rvc_decoder.sv
// Directed-vector bench for rvc_decoder, full and embedded register file variants.
module tb_rvc_decoder;

  typedef struct packed {
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [3:0]  lsu;
    logic        mc;
    logic        aluImm;
    logic [3:0]  aluOp;
    logic        inv;
    logic        pcWb;
    logic [1:0]  pcMode;
  } dec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] instr;

  logic [4:0]  rs1A, rs2A, rdA, rs1B, rs2B, rdB;
  logic [31:0] immA, immB;
  logic [3:0]  lsuA, lsuB, aluOpA, aluOpB;
  logic        mcA, mcB, aluImmA, aluImmB, invA, invB, pcWbA, pcWbB;
  logic [1:0]  pcModeA, pcModeB;
  dec_t        obsA, obsB;

  int assertCount = 0;
  int failCount   = 0;

  always #5 clk = ~clk;

  rvc_decoder #(.embedded(1'b0)) dutFull (
    .clk(clk), .rst(rst), .InstructionIn(instr),
    .Rs1(rs1A), .Rs2(rs2A), .Rd(rdA), .Immediate(immA), .CtrlLSU(lsuA),
    .CtrlMultiCycle(mcA), .CtrlALUImm(aluImmA), .CtrlALUOp(aluOpA),
    .CtrlFlagInv(invA), .CtrlPCWriteback(pcWbA), .CtrlPCMode(pcModeA)
  );

  rvc_decoder #(.embedded(1'b1)) dutEmb (
    .clk(clk), .rst(rst), .InstructionIn(instr),
    .Rs1(rs1B), .Rs2(rs2B), .Rd(rdB), .Immediate(immB), .CtrlLSU(lsuB),
    .CtrlMultiCycle(mcB), .CtrlALUImm(aluImmB), .CtrlALUOp(aluOpB),
    .CtrlFlagInv(invB), .CtrlPCWriteback(pcWbB), .CtrlPCMode(pcModeB)
  );

  assign obsA = {rs1A, rs2A, rdA, immA, lsuA, mcA, aluImmA, aluOpA, invA, pcWbA, pcModeA};
  assign obsB = {rs1B, rs2B, rdB, immB, lsuB, mcB, aluImmB, aluOpB, invB, pcWbB, pcModeB};

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    assertCount++;
    if (got !== exp) begin
      failCount++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic dec_t mk(input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic [4:0] rd, input logic [31:0] imm,
                              input logic [3:0] lsu, input logic mc, input logic aluImm,
                              input logic [3:0] aluOp, input logic inv, input logic pcWb,
                              input logic [1:0] pcMode);
    dec_t d;
    d.rs1 = rs1; d.rs2 = rs2; d.rd = rd; d.imm = imm; d.lsu = lsu; d.mc = mc;
    d.aluImm = aluImm; d.aluOp = aluOp; d.inv = inv; d.pcWb = pcWb; d.pcMode = pcMode;
    return d;
  endfunction

  task automatic checkDec(input string tag, input dec_t got, input dec_t exp);
    checkVal({tag, ".Rs1"},    32'(got.rs1),    32'(exp.rs1));
    checkVal({tag, ".Rs2"},    32'(got.rs2),    32'(exp.rs2));
    checkVal({tag, ".Rd"},     32'(got.rd),     32'(exp.rd));
    checkVal({tag, ".Imm"},    got.imm,         exp.imm);
    checkVal({tag, ".LSU"},    32'(got.lsu),    32'(exp.lsu));
    checkVal({tag, ".MC"},     32'(got.mc),     32'(exp.mc));
    checkVal({tag, ".ALUImm"}, 32'(got.aluImm), 32'(exp.aluImm));
    checkVal({tag, ".ALUOp"},  32'(got.aluOp),  32'(exp.aluOp));
    checkVal({tag, ".Inv"},    32'(got.inv),    32'(exp.inv));
    checkVal({tag, ".PCWb"},   32'(got.pcWb),   32'(exp.pcWb));
    checkVal({tag, ".PCMode"}, 32'(got.pcMode), 32'(exp.pcMode));
  endtask

  task automatic drive(input logic [15:0] ins);
    @(negedge clk);
    instr = ins;
    #1;
  endtask

  task automatic runVec(input logic [15:0] ins, input dec_t exp);
    drive(ins);
    checkDec($sformatf("%04h", ins), obsA, exp);
  endtask

  // exp carries the completion-cycle values; the address cycle forces MC=1, Rd=0
  task automatic lsTest(input logic [15:0] ins, input dec_t exp);
    dec_t e0;
    e0 = exp; e0.mc = 1'b1; e0.rd = 5'd0;
    drive(ins);
    checkDec($sformatf("%04h.ph0", ins), obsA, e0);
    @(negedge clk); #1;
    checkDec($sformatf("%04h.ph1", ins), obsA, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    dec_t lw, lw0;
    lw  = mk(8, 0, 9, 4, 4'b0001, 0, 1, 4'b0101, 0, 0, 2'b00);
    lw0 = lw; lw0.mc = 1'b1; lw0.rd = 5'd0;

    // Reset holds the phase at the address cycle even with a load presented
    rst = 1'b1;
    instr = 16'h4044;
    repeat (3) @(posedge clk);
    drive(16'h4044);
    checkDec("rst", obsA, lw0);
    drive(16'h4044);
    checkDec("rstHold", obsA, lw0);
    rst = 1'b0;
    runVec(16'h0000, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00));

    // Quadrant 1 arithmetic and immediates
    runVec(16'h4515, mk(0, 0, 10, 32'd5,        0, 0, 1, 4'b0101, 0, 0, 2'b00));
    runVec(16'h557D, mk(0, 0, 10, 32'hFFFFFFFF, 0, 0, 1, 4'b0101, 0, 0, 2'b00));
    runVec(16'h14F5, mk(9, 0, 9,  32'hFFFFFFFD, 0, 0, 1, 4'b0101, 0, 0, 2'b00));
    runVec(16'h6505, mk(0, 0, 10, 32'h00001000, 0, 0, 1, 4'b0101, 0, 0, 2'b00));
    runVec(16'h757D, mk(0, 0, 10, 32'hFFFFF000, 0, 0, 1, 4'b0101, 0, 0, 2'b00));
    runVec(16'h6141, mk(2, 0, 2,  32'd16,       0, 0, 1, 4'b0101, 0, 0, 2'b00));
    runVec(16'h717D, mk(2, 0, 2,  32'hFFFFFFF0, 0, 0, 1, 4'b0101, 0, 0, 2'b00));
    runVec(16'h840D, mk(8, 0, 8,  32'd3,        0, 0, 1, 4'b1011, 0, 0, 2'b00));
    runVec(16'h800D, mk(8, 0, 8,  32'd3,        0, 0, 1, 4'b1010, 0, 0, 2'b00));
    runVec(16'h987D, mk(8, 0, 8,  32'hFFFFFFFF, 0, 0, 1, 4'b0011, 0, 0, 2'b00));
    runVec(16'h8C05, mk(8, 9, 8,  0,            0, 0, 0, 4'b0100, 0, 0, 2'b00));
    runVec(16'h8C25, mk(8, 9, 8,  0,            0, 0, 0, 4'b0001, 0, 0, 2'b00));
    runVec(16'h8C45, mk(8, 9, 8,  0,            0, 0, 0, 4'b0010, 0, 0, 2'b00));
    runVec(16'h8C65, mk(8, 9, 8,  0,            0, 0, 0, 4'b0011, 0, 0, 2'b00));

    // Control flow
    runVec(16'hE011, mk(8, 0, 0, 32'd4,        0, 0, 0, 4'b1111, 1, 0, 2'b01));
    runVec(16'hC091, mk(9, 0, 0, 32'd4,        0, 0, 0, 4'b1111, 0, 0, 2'b01));
    runVec(16'hFC7D, mk(8, 0, 0, 32'hFFFFFFFE, 0, 0, 0, 4'b1111, 1, 0, 2'b01));
    runVec(16'h2021, mk(0, 0, 1, 32'd8,        0, 0, 0, 4'b0000, 0, 1, 2'b11));
    runVec(16'hBFFD, mk(0, 0, 0, 32'hFFFFFFFE, 0, 0, 0, 4'b0000, 0, 0, 2'b11));
    runVec(16'h8282, mk(5, 0, 0, 0,            0, 0, 0, 4'b0000, 0, 0, 2'b10));
    runVec(16'h9282, mk(5, 0, 1, 0,            0, 0, 0, 4'b0000, 0, 1, 2'b10));

    // Quadrants 0 and 2 non-memory
    runVec(16'h0040, mk(2, 0, 8,  32'd4,   0, 0, 1, 4'b0101, 0, 0, 2'b00));
    runVec(16'h0784, mk(2, 0, 9,  32'h3C0, 0, 0, 1, 4'b0101, 0, 0, 2'b00));
    runVec(16'h0512, mk(10, 0, 10, 32'd4,  0, 0, 1, 4'b1000, 0, 0, 2'b00));
    runVec(16'h9426, mk(8, 9, 8,  0,       0, 0, 0, 4'b0101, 0, 0, 2'b00));
    checkDec("emb9426", obsB, mk(8, 9, 8, 0, 0, 0, 0, 4'b0101, 0, 0, 2'b00));
    runVec(16'h88CA, mk(0, 18, 17, 0,      0, 0, 0, 4'b0101, 0, 0, 2'b00));
    checkDec("emb88CA", obsB, mk(0, 2, 1, 0, 0, 0, 0, 4'b0101, 0, 0, 2'b00));

    // Invalid and unsupported encodings decode as NOP
    runVec(16'h9002, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00));
    runVec(16'h4517, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00));
    runVec(16'h6044, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00));
    runVec(16'h0000, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00));

    // Two-cycle loads and stores
    lsTest(16'h4044, lw);
    lsTest(16'hC044, mk(8, 9, 0,  32'd4,  4'b0101, 0, 1, 4'b0101, 0, 0, 2'b00));
    lsTest(16'h4532, mk(2, 0, 10, 32'd12, 4'b0001, 0, 1, 4'b0101, 0, 0, 2'b00));
    lsTest(16'hC42E, mk(2, 11, 0, 32'd8,  4'b0101, 0, 1, 4'b0101, 0, 0, 2'b00));

    // Reset during the completion cycle restarts the sequence at the address cycle
    drive(16'h4044);
    checkDec("rp.ph0", obsA, lw0);
    @(negedge clk); #1;
    checkDec("rp.ph1", obsA, lw);
    rst = 1'b1;
    @(negedge clk); #1;
    checkDec("rp.rst", obsA, lw0);
    @(negedge clk); #1;
    checkDec("rp.hold", obsA, lw0);
    rst = 1'b0;
    @(negedge clk); #1;
    checkDec("rp.after", obsA, lw);
    runVec(16'h4515, mk(0, 0, 10, 32'd5, 0, 0, 1, 4'b0101, 0, 0, 2'b00));

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
